// File: rtl/apb2ahb_pkg.sv
// Shared encodings and FSM state type for the APB3-to-AHB-Lite bridge.
// No logic; latency and backpressure are properties of the bridge itself.
// Imported by apb2ahb_bridge and apb2ahb_strb_dec.
package apb2ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/apb2ahb_strb_dec.sv
// Decodes a write byte strobe into AHB transfer size and low address bits.
// Purely combinational, zero latency; no flow control.
// Strobes that are not a full word, an aligned half or a single byte are flagged illegal.
module apb2ahb_strb_dec
    import apb2ahb_pkg::*;
(
    input  logic [3:0] strb,
    output logic [2:0] hsize,
    output logic [1:0] addr_lo,
    output logic       illegal
);

    always_comb begin
        hsize   = HSIZE_WORD;
        addr_lo = 2'b00;
        illegal = 1'b0;
        case (strb)
            4'b1111: hsize = HSIZE_WORD;
            4'b0011: hsize = HSIZE_HALF;
            4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
            4'b0001: begin hsize = HSIZE_BYTE; addr_lo = 2'b00; end
            4'b0010: begin hsize = HSIZE_BYTE; addr_lo = 2'b01; end
            4'b0100: begin hsize = HSIZE_BYTE; addr_lo = 2'b10; end
            4'b1000: begin hsize = HSIZE_BYTE; addr_lo = 2'b11; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/apb2ahb_bridge.sv
// APB3 responder issuing one AHB-Lite SINGLE NONSEQ transfer per APB access (APB2AHB_APB4_EN adds PPROT/PSTRB).
// Latency: at least 3 HCLK from the APB setup edge to PREADY with a zero-wait AHB slave.
// Backpressure: PREADY stays low until the AHB data phase completes; AHB HREADY=0 holds each phase.
module apb2ahb_bridge
    import apb2ahb_pkg::*;
#(
    parameter int          ADDRWIDTH     = 16,
    parameter int          DATAWIDTH     = 32,
    parameter logic [31:0] BASE_ADDR     = 32'h4000_0000,
    parameter logic [3:0]  HPROT_DEFAULT = 4'b0011
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 PCLKEN,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PWRITE,
`ifdef APB2AHB_APB4_EN
    input  logic [2:0]           PPROT,
    input  logic [3:0]           PSTRB,
`endif
    input  logic [DATAWIDTH-1:0] PWDATA,
    output logic                 PREADY,
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 PSLVERR,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [3:0]           HPROT,
    output logic                 HMASTLOCK,
    output logic [DATAWIDTH-1:0] HWDATA,
    input  logic [DATAWIDTH-1:0] HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    output logic                 APBACTIVE
);

    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDRWIDTH) - 64'd1);

    state_t               state, state_nxt;
    logic                 setup;
    logic [31:0]          addr_full;
    logic [31:0]          setup_addr;
    logic [2:0]           setup_size;
    logic [3:0]           setup_prot;
    logic                 setup_err;

    logic [31:0]          haddr_q;
    logic                 hwrite_q;
    logic [2:0]           hsize_q;
    logic [3:0]           hprot_q;
    logic [DATAWIDTH-1:0] hwdata_q;
    logic [DATAWIDTH-1:0] prdata_q;
    logic                 err_q;

    assign setup     = (state == ST_IDLE) && PCLKEN && PSEL && !PENABLE;
    assign addr_full = (BASE_ADDR & ~ADDR_MASK) | 32'(PADDR);

`ifdef APB2AHB_APB4_EN
    logic [2:0] strb_size;
    logic [1:0] strb_lo;
    logic       strb_illegal;
    logic       unused_pprot;

    apb2ahb_strb_dec u_strb_dec (
        .strb    (PSTRB),
        .hsize   (strb_size),
        .addr_lo (strb_lo),
        .illegal (strb_illegal)
    );

    // Reads always move a full word; only writes are shaped by the strobe.
    assign setup_err    = PWRITE & strb_illegal;
    assign setup_size   = PWRITE ? strb_size : HSIZE_WORD;
    assign setup_addr   = PWRITE ? {addr_full[31:2], strb_lo} : addr_full;
    assign setup_prot   = {2'b00, PPROT[0], ~PPROT[2]};
    assign unused_pprot = PPROT[1];
`else
    assign setup_err  = 1'b0;
    assign setup_size = HSIZE_WORD;
    assign setup_addr = addr_full;
    assign setup_prot = HPROT_DEFAULT;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    state_nxt = setup_err ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                // A dropped PSEL also releases RESP, so a misbehaving master cannot wedge the bridge.
                if (PCLKEN && (!PSEL || PENABLE)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_WORD;
            hprot_q  <= HPROT_DEFAULT;
            hwdata_q <= '0;
            prdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (setup) begin
                haddr_q  <= setup_addr;
                hwrite_q <= PWRITE;
                hsize_q  <= setup_size;
                hprot_q  <= setup_prot;
                hwdata_q <= PWDATA;
                err_q    <= setup_err;
            end
            // HRESP only counts on the completing cycle of an ERROR response.
            if ((state == ST_DATA) && HREADY) begin
                err_q <= HRESP;
                if (!hwrite_q) begin
                    prdata_q <= HRDATA;
                end
            end
        end
    end

    assign HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HPROT     = hprot_q;
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_q;
    assign PREADY    = (state == ST_RESP);
    assign PSLVERR   = (state == ST_RESP) && err_q;
    assign PRDATA    = prdata_q;
    assign APBACTIVE = (state != ST_IDLE);

endmodule

// File: tb/tb_apb2ahb_bridge.sv
// Directed bench for apb2ahb_bridge with a scripted AHB responder (wait states, ERROR responses).
// Builds with or without APB2AHB_APB4_EN.
module tb_apb2ahb_bridge;

    logic        HCLK;
    logic        HRESET;
    logic        PCLKEN;
    logic        PSEL;
    logic        PENABLE;
    logic [15:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        APBACTIVE;
`ifdef APB2AHB_APB4_EN
    logic [2:0]  PPROT;
    logic [3:0]  PSTRB;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Responder script: wait states per phase, HRESP mode (0 OKAY, 1 ERROR, 2 HRESP only in wait cycles).
    int          addr_wait  = 0;
    int          data_wait  = 0;
    int          hresp_mode = 0;
    logic [31:0] rd_val     = 32'h0;

    apb2ahb_bridge dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .PCLKEN    (PCLKEN),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
`ifdef APB2AHB_APB4_EN
        .PPROT     (PPROT),
        .PSTRB     (PSTRB),
`endif
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .APBACTIVE (APBACTIVE)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // AHB slave model: reacts one cycle at a time, #1 after each edge.
    initial begin
        int ph;
        int cnt;
        ph = 0;
        cnt = 0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
        forever begin
            @(posedge HCLK);
            if (HRESET) begin
                ph = 0;
                cnt = 0;
            end
            #1;
            HREADY = 1'b1;
            HRESP  = 1'b0;
            HRDATA = 32'hBAD0_BAD0;
            if (ph == 0) begin
                if (HTRANS == 2'b10) begin
                    if (cnt < addr_wait) begin
                        HREADY = 1'b0;
                        cnt++;
                    end else begin
                        cnt = 0;
                        ph = 1;
                    end
                end
            end else begin
                if (cnt < data_wait) begin
                    HREADY = 1'b0;
                    HRESP  = (hresp_mode != 0);
                    cnt++;
                end else begin
                    HRDATA = rd_val;
                    HRESP  = (hresp_mode == 1);
                    cnt = 0;
                    ph = 0;
                end
            end
        end
    end

    // One full APB access at PCLKEN=1; lat counts edges from the setup edge until PREADY is seen.
    task automatic apb_access(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                              output int lat, output int nonseq, output int bad_addr,
                              output logic [31:0] seen_hwdata, output logic [31:0] rdata,
                              output logic err);
        PCLKEN = 1'b1;
        PSEL = 1'b1;
        PENABLE = 1'b0;
        PWRITE = wr;
        PADDR = addr;
        PWDATA = wdata;
        nonseq = 0;
        bad_addr = 0;
        seen_hwdata = 32'h0;
        tick();
        lat = 1;
        PENABLE = 1'b1;
        while (!PREADY && lat < 50) begin
            if (HTRANS == 2'b10) begin
                nonseq++;
                if (HADDR !== {16'h4000, addr} || HWRITE !== wr) bad_addr++;
            end else if (APBACTIVE) begin
                seen_hwdata = HWDATA;
            end
            tick();
            lat++;
        end
        check_eq("ready_timeout", 32'(PREADY), 32'd1);
        rdata = PRDATA;
        err = PSLVERR;
        tick();
        PSEL = 1'b0;
        PENABLE = 1'b0;
        check_eq("idle_after", 32'(APBACTIVE), 32'd0);
    endtask

    initial begin
        int          lat, nsq, bad;
        logic [31:0] hwd, rd;
        logic        er;
        logic [7:0]  exp_act, exp_rdy;

        HRESET = 1'b1;
        PCLKEN = 1'b1;
        PSEL = 1'b0;
        PENABLE = 1'b0;
        PADDR = 16'h0;
        PWRITE = 1'b0;
        PWDATA = 32'h0;
`ifdef APB2AHB_APB4_EN
        PPROT = 3'b001;
        PSTRB = 4'b1111;
`endif
        repeat (3) tick();
        check_eq("rst_htrans", 32'(HTRANS), 32'd0);
        check_eq("rst_haddr", HADDR, 32'h0);
        check_eq("rst_hwrite", 32'(HWRITE), 32'd0);
        check_eq("rst_hwdata", HWDATA, 32'h0);
        check_eq("rst_pready", 32'(PREADY), 32'd0);
        check_eq("rst_prdata", PRDATA, 32'h0);
        check_eq("rst_pslverr", 32'(PSLVERR), 32'd0);
        check_eq("rst_apbactive", 32'(APBACTIVE), 32'd0);
        check_eq("rst_hsize", 32'(HSIZE), 32'd2);
        check_eq("rst_hprot", 32'(HPROT), 32'h3);
        check_eq("rst_hburst", 32'(HBURST), 32'd0);
        check_eq("rst_hmastlock", 32'(HMASTLOCK), 32'd0);
        HRESET = 1'b0;
        tick();

        // Zero-wait write
        apb_access(1'b1, 16'h0010, 32'hDEAD_BEEF, lat, nsq, bad, hwd, rd, er);
        check_eq("t1_latency", 32'(lat), 32'd3);
        check_eq("t1_nonseq_cycles", 32'(nsq), 32'd1);
        check_eq("t1_haddr", 32'(bad), 32'd0);
        check_eq("t1_hwdata", hwd, 32'hDEAD_BEEF);
        check_eq("t1_pslverr", 32'(er), 32'd0);
        check_eq("t1_prdata_unchanged", rd, 32'h0);

        // Read with 2 address-phase and 3 data-phase wait states
        addr_wait = 2;
        data_wait = 3;
        rd_val = 32'h1234_5678;
        apb_access(1'b0, 16'h0020, 32'h0, lat, nsq, bad, hwd, rd, er);
        check_eq("t2_latency", 32'(lat), 32'd8);
        check_eq("t2_nonseq_cycles", 32'(nsq), 32'd3);
        check_eq("t2_addr_held", 32'(bad), 32'd0);
        check_eq("t2_prdata", rd, 32'h1234_5678);
        check_eq("t2_pslverr", 32'(er), 32'd0);

        // Two-cycle AHB ERROR on a read
        addr_wait = 0;
        data_wait = 1;
        hresp_mode = 1;
        apb_access(1'b0, 16'h0024, 32'h0, lat, nsq, bad, hwd, rd, er);
        check_eq("t3_err_latency", 32'(lat), 32'd4);
        check_eq("t3_err_pslverr", 32'(er), 32'd1);

        // HRESP during an HREADY=0 cycle only must not flag an error
        hresp_mode = 2;
        rd_val = 32'hCAFE_F00D;
        apb_access(1'b0, 16'h0028, 32'h0, lat, nsq, bad, hwd, rd, er);
        check_eq("t3_wait_hresp_ignored", 32'(er), 32'd0);
        check_eq("t3_next_prdata", rd, 32'hCAFE_F00D);

        hresp_mode = 0;
        data_wait = 0;
        apb_access(1'b1, 16'h002C, 32'h0BAD_F00D, lat, nsq, bad, hwd, rd, er);
        check_eq("t3_write_pslverr", 32'(er), 32'd0);
        check_eq("t3_write_keeps_prdata", rd, 32'hCAFE_F00D);
        check_eq("t3_write_hwdata", hwd, 32'h0BAD_F00D);

        // PSEL dropped after setup: AHB transfer still runs, RESP exits without handshake
        PSEL = 1'b1;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
        PADDR = 16'h0040;
        tick();
        check_eq("pv_nonseq", 32'(HTRANS), 32'h2);
        PSEL = 1'b0;
        tick();
        tick();
        check_eq("pv_resp", 32'(PREADY), 32'd1);
        tick();
        check_eq("pv_idle", 32'(APBACTIVE), 32'd0);

        // PCLKEN on every 4th edge
        exp_act = 8'b0111_1000;
        exp_rdy = 8'b0110_0000;
        PSEL = 1'b1;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
        PADDR = 16'h0060;
        for (int i = 0; i < 8; i++) begin
            PCLKEN = (i % 4 == 3);
            tick();
            check_eq($sformatf("t4_apbactive_%0d", i), 32'(APBACTIVE), 32'(exp_act[i]));
            check_eq($sformatf("t4_pready_%0d", i), 32'(PREADY), 32'(exp_rdy[i]));
            if (i == 3) PENABLE = 1'b1;
        end
        PSEL = 1'b0;
        PENABLE = 1'b0;
        PCLKEN = 1'b1;

        // Reset while in the data phase
        data_wait = 5;
        PSEL = 1'b1;
        PWRITE = 1'b1;
        PADDR = 16'h0050;
        PWDATA = 32'h1111_2222;
        tick();
        PENABLE = 1'b1;
        tick();
        check_eq("t5_in_data", 32'(APBACTIVE && HTRANS == 2'b00), 32'd1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        PSEL = 1'b0;
        PENABLE = 1'b0;
        check_eq("t5_htrans", 32'(HTRANS), 32'd0);
        check_eq("t5_pready", 32'(PREADY), 32'd0);
        check_eq("t5_apbactive", 32'(APBACTIVE), 32'd0);
        check_eq("t5_prdata", PRDATA, 32'h0);
        check_eq("t5_hwdata", HWDATA, 32'h0);
        data_wait = 0;
        apb_access(1'b1, 16'h0054, 32'h3333_4444, lat, nsq, bad, hwd, rd, er);
        check_eq("t5_after_latency", 32'(lat), 32'd3);
        check_eq("t5_after_hwdata", hwd, 32'h3333_4444);
        check_eq("t5_after_pslverr", 32'(er), 32'd0);

`ifdef APB2AHB_APB4_EN
        // Byte strobe on lane 2 and protection mapping
        PSTRB = 4'b0100;
        PPROT = 3'b001;
        PSEL = 1'b1;
        PENABLE = 1'b0;
        PWRITE = 1'b1;
        PADDR = 16'h0030;
        PWDATA = 32'h00AB_0000;
        tick();
        check_eq("t6_htrans", 32'(HTRANS), 32'h2);
        check_eq("t6_hsize", 32'(HSIZE), 32'd0);
        check_eq("t6_haddr", HADDR, 32'h4000_0032);
        check_eq("t6_hprot", 32'(HPROT), 32'h3);
        PENABLE = 1'b1;
        tick();
        tick();
        check_eq("t6_pready", 32'(PREADY), 32'd1);
        tick();
        PSEL = 1'b0;
        PENABLE = 1'b0;
        // Illegal strobe: straight to RESP with an error, no AHB transfer
        PSTRB = 4'b0110;
        PSEL = 1'b1;
        tick();
        check_eq("t6_bad_htrans", 32'(HTRANS), 32'd0);
        check_eq("t6_bad_pready", 32'(PREADY), 32'd1);
        check_eq("t6_bad_pslverr", 32'(PSLVERR), 32'd1);
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0;
        PENABLE = 1'b0;
        check_eq("t6_bad_idle", 32'(APBACTIVE), 32'd0);
        PSTRB = 4'b1111;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
